instr_decode_unit: RTL and testbench
====================================

INSTR_DECODE_UNIT -- requirements
Module: instr_decode_unit

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, architectural register count (32 = RV32I, 16 = RV32E).
REQ-002 SHALL have parameter WB_BYPASS, default 1, write-through bypass from the WB write port to the read ports.
REQ-003 SHALL have parameter HAZARD_EN, default 1, load-use bubble insertion enable.
REQ-004 SHALL have parameter CNT_W, default 16, stall counter width.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 reset_n  input  1  synchronous, active-low reset.
REQ-007 if_valid_i / if_instr_i / if_pc_i  input  1/32/32  instruction offered by IF.
REQ-008 id_ready_o  output  1  decode accepts the offered instruction this cycle.
REQ-009 wb_rd_addr_i / wb_rd_data_i / wb_rd_write_i  input  5/32/1  register file write port.
REQ-010 ex_ready_i  input  1  EX accepts the ID/EX register contents this cycle.
REQ-011 flush_i  input  1  discard the ID/EX contents and the offered instruction.
REQ-012 ex_valid_o  output  1  ID/EX register holds a valid instruction.
REQ-013 ex_pc_o, ex_op1_o, ex_op2_o, ex_imm_o  output  32 each  PC, rs1 data, rs2 data, extended immediate.
REQ-014 ex_alu_op_o  output  4  ALU encoding per definitions.vh; ex_func3_o  output  3  instr[14:12].
REQ-015 ex_use_imm_o, ex_use_pc_o, ex_branch_o, ex_jump_o, ex_read_mem_o, ex_write_mem_o, ex_use_mem_o, ex_write_reg_o, ex_illegal_o  output  1 each  control flags.
REQ-016 ex_rs1_o, ex_rs2_o, ex_rd_o  output  5 each  register addresses; stall_cnt_o  output  CNT_W  load-use stall count.

Function
REQ-017 Register file SHALL have NUM_REGS x 32 bits, reading combinationally; x0 reads 0; writes to x0 are ignored.
REQ-018 With WB_BYPASS=1, a read whose address equals wb_rd_addr_i (nonzero) while wb_rd_write_i=1 SHALL return wb_rd_data_i in the same cycle.
REQ-019 load_en = !ex_valid_o || ex_ready_i; hazard = HAZARD_EN && ex_valid_o && ex_read_mem_o && ex_rd_o!=0 && (ex_rd_o==rs1 used || ex_rd_o==rs2 used).
REQ-020 rs1 SHALL count as used by all opcodes except LUI, AUIPC, and JAL; rs2 SHALL count as used by ARITH, STORE, and BRANCH only.
REQ-021 id_ready_o = flush_i || (load_en && !hazard).
REQ-022 When load_en, !hazard, and !flush_i, the ID/EX register SHALL capture the decoded instruction with ex_valid_o=if_valid_i, giving a latency of 1 cycle.
REQ-023 When load_en, hazard, and !flush_i, a bubble SHALL be loaded: ex_valid_o=0, all control flags 0, and stall_cnt_o incremented, saturating at all-ones.
REQ-024 When !load_en and !flush_i, all ID/EX outputs SHALL hold.
REQ-025 flush_i SHALL take priority over load, hold, and hazard: next cycle ex_valid_o=0 and all flags 0; the offered instruction is dropped.
REQ-026 Immediates SHALL be sign-extended as follows: LOAD/JALR/ARITH_IMM = I, STORE = S, BRANCH = B with bit0=0, JAL = J with bit0=0, and LUI/AUIPC = U.
REQ-027 The B-type and J-type immediate forms SHALL include the implicit zero LSB.
REQ-028 Control SHALL be decoded as follows:
- LUI: write_reg=1, use_imm=1, op1=0, ALU_ADD.
- AUIPC: write_reg=1, use_pc=1, use_imm=1, ALU_ADD.
- JAL: jump=1, write_reg=1, use_pc=1, use_imm=1.
- JALR: jump=1, write_reg=1, use_imm=1, ALU_ADD.
- LOAD: read_mem=1, use_mem=1, write_reg=1, use_imm=1, ALU_ADD.
- STORE: write_mem=1, use_imm=1, ALU_ADD.
- BRANCH: branch=1, ALU_SUB.
- ARITH / ARITH_IMM: write_reg=1; use_imm=1 for ARITH_IMM only.
REQ-029 ALU selection by func3: 000 SHALL select ALU_SUB only for ARITH with instr[30]=1, else ALU_ADD.
REQ-030 Func3 values 001, 010, 011, 100, 110, and 111 SHALL select SLL, SLT, SLTU, XOR, OR, and AND respectively.
REQ-031 Func3 101 SHALL select SRA when instr[30]=1, else SRL.
REQ-032 ex_illegal_o=1 SHALL be raised for an unknown opcode, instr[1:0]!=2'b11, or any used rs1, rs2, or written rd index >= NUM_REGS.
REQ-033 An illegal instruction SHALL force write_reg, write_mem, read_mem, branch, and jump to 0, while ex_valid_o still follows if_valid_i.
REQ-034 ex_pc_o SHALL equal if_pc_i of the captured instruction; ex_rs1_o, ex_rs2_o, and ex_rd_o SHALL equal the raw instruction fields.

Reset
REQ-035 While reset_n=0 at a clock edge, all ID/EX outputs, ex_valid_o, and stall_cnt_o SHALL become 0, and all register file entries SHALL be cleared to 0.
REQ-036 A reset asserted mid-stall or mid-hold SHALL override everything, including flush_i.

Verification
REQ-037 addi x5,x0,-1 (0xFFF00293) valid, ex_ready_i=1 -> next cycle ex_valid_o=1, ex_imm_o=0xFFFFFFFF, ALU_ADD, use_imm=1, write_reg=1, rd=5.
REQ-038 lw x6,0(x1) then add x7,x6,x2 -> one bubble: id_ready_o=0 for 1 cycle, ex_valid_o=0 for 1 cycle, stall_cnt_o=1; the add is issued the following cycle.
REQ-039 WB writes x3=0x12345678 in the same cycle as decoding add x4,x3,x0 with WB_BYPASS=1 -> ex_op1_o=0x12345678.
REQ-040 ex_ready_i=0 for 3 cycles with a valid sub in ID/EX -> outputs are stable and id_ready_o=0; flush_i=1 then -> ex_valid_o=0 next cycle.
REQ-041 NUM_REGS=16 and add x20,x1,x2 -> ex_illegal_o=1 and write_reg=0.
REQ-042 jal x1,+8 (0x008000EF) -> ex_imm_o=8, jump=1, use_pc=1, write_reg=1.

Source files
------------

// File: rtl/instr_decode_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_decode_unit_if
//  Description : Bundles the IF offer, WB register write port and ID/EX
//                output bus of the decode stage.
//                slave  modport: decode unit (takes IF/WB/EX-ready, drives EX)
//                master modport: environment (drives IF/WB/EX-ready/flush)
//  Ports       : if_valid_i/if_instr_i/if_pc_i, id_ready_o,
//                wb_rd_addr_i/wb_rd_data_i/wb_rd_write_i, ex_ready_i, flush_i,
//                ex_* decoded fields and flags, stall_cnt_o [CNT_W]
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_decode_unit_if #(
    parameter int CNT_W = 16
) ();
    logic             if_valid_i;
    logic [31:0]      if_instr_i;
    logic [31:0]      if_pc_i;
    logic             id_ready_o;
    logic [4:0]       wb_rd_addr_i;
    logic [31:0]      wb_rd_data_i;
    logic             wb_rd_write_i;
    logic             ex_ready_i;
    logic             flush_i;
    logic             ex_valid_o;
    logic [31:0]      ex_pc_o;
    logic [31:0]      ex_op1_o;
    logic [31:0]      ex_op2_o;
    logic [31:0]      ex_imm_o;
    logic [3:0]       ex_alu_op_o;
    logic [2:0]       ex_func3_o;
    logic             ex_use_imm_o;
    logic             ex_use_pc_o;
    logic             ex_branch_o;
    logic             ex_jump_o;
    logic             ex_read_mem_o;
    logic             ex_write_mem_o;
    logic             ex_use_mem_o;
    logic             ex_write_reg_o;
    logic             ex_illegal_o;
    logic [4:0]       ex_rs1_o;
    logic [4:0]       ex_rs2_o;
    logic [4:0]       ex_rd_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport slave (
        input  if_valid_i, if_instr_i, if_pc_i,
        input  wb_rd_addr_i, wb_rd_data_i, wb_rd_write_i,
        input  ex_ready_i, flush_i,
        output id_ready_o, ex_valid_o, ex_pc_o, ex_op1_o, ex_op2_o, ex_imm_o,
        output ex_alu_op_o, ex_func3_o, ex_use_imm_o, ex_use_pc_o, ex_branch_o,
        output ex_jump_o, ex_read_mem_o, ex_write_mem_o, ex_use_mem_o,
        output ex_write_reg_o, ex_illegal_o, ex_rs1_o, ex_rs2_o, ex_rd_o,
        output stall_cnt_o
    );

    modport master (
        output if_valid_i, if_instr_i, if_pc_i,
        output wb_rd_addr_i, wb_rd_data_i, wb_rd_write_i,
        output ex_ready_i, flush_i,
        input  id_ready_o, ex_valid_o, ex_pc_o, ex_op1_o, ex_op2_o, ex_imm_o,
        input  ex_alu_op_o, ex_func3_o, ex_use_imm_o, ex_use_pc_o, ex_branch_o,
        input  ex_jump_o, ex_read_mem_o, ex_write_mem_o, ex_use_mem_o,
        input  ex_write_reg_o, ex_illegal_o, ex_rs1_o, ex_rs2_o, ex_rd_o,
        input  stall_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/instr_decode_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_decode_unit
//  Description : RV32I/E decode stage: register file with optional WB
//                write-through, instruction decoder, load-use bubble
//                insertion and the ID/EX pipeline register.
//  Ports       : clk      - clock, rising edge
//                reset_n  - synchronous active-low reset
//                bus      - instr_decode_unit_if.slave (IF offer, WB write
//                           port, EX handshake/flush, ID/EX outputs)
//  ALU codes   : ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_decode_unit #(
    parameter int NUM_REGS  = 32,
    parameter int WB_BYPASS = 1,
    parameter int HAZARD_EN = 1,
    parameter int CNT_W     = 16
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    instr_decode_unit_if.slave bus
);
    localparam int         AW   = $clog2(NUM_REGS);
    localparam logic [5:0] NREG = 6'(NUM_REGS);

    localparam logic [6:0] OP_LUI       = 7'b0110111;
    localparam logic [6:0] OP_AUIPC     = 7'b0010111;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_ARITH     = 7'b0110011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    // Control flags grouped so a bubble/flush can clear them in one go.
    typedef struct packed {
        logic use_imm;
        logic use_pc;
        logic branch;
        logic jump;
        logic read_mem;
        logic write_mem;
        logic use_mem;
        logic write_reg;
        logic illegal;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic [2:0]  func3;
        ctrl_t       ctrl;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } ex_t;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [31:0] rf_q [NUM_REGS];
    logic [31:0] rf_d [NUM_REGS];

    logic wb_we;
    assign wb_we = bus.wb_rd_write_i && (bus.wb_rd_addr_i != 5'd0) &&
                   ({1'b0, bus.wb_rd_addr_i} < NREG);

    always_comb begin
        rf_d = rf_q;
        if (wb_we) begin
            rf_d[bus.wb_rd_addr_i[AW-1:0]] = bus.wb_rd_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            rf_q <= rf_d;
        end
    end

    // x0 and out-of-range indices read as zero; an in-flight WB write to
    // the same register is forwarded when the bypass is enabled.
    function automatic logic [31:0] rf_read(input logic [4:0] a);
        logic [31:0] r;
        r = '0;
        if (a != 5'd0 && {1'b0, a} < NREG) begin
            if (WB_BYPASS != 0 && wb_we && bus.wb_rd_addr_i == a) begin
                r = bus.wb_rd_data_i;
            end else begin
                r = rf_q[a[AW-1:0]];
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    logic        rs1_used, rs2_used;
    logic        known, op1_zero;
    ex_t         dec;

    assign instr  = bus.if_instr_i;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};

    assign rs1_used = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    assign rs2_used = (opcode == OP_ARITH) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

    // Subtract only exists in register-register form; the shift-right
    // arithmetic select applies to both register and immediate shifts.
    function automatic logic [3:0] alu_sel(input logic [2:0] fn, input logic b30,
                                           input logic is_reg);
        logic [3:0] a;
        case (fn)
            3'b000:  a = (is_reg && b30) ? ALU_SUB : ALU_ADD;
            3'b001:  a = ALU_SLL;
            3'b010:  a = ALU_SLT;
            3'b011:  a = ALU_SLTU;
            3'b100:  a = ALU_XOR;
            3'b101:  a = b30 ? ALU_SRA : ALU_SRL;
            3'b110:  a = ALU_OR;
            default: a = ALU_AND;
        endcase
        return a;
    endfunction

    always_comb begin
        dec       = '0;
        dec.pc    = bus.if_pc_i;
        dec.func3 = f3;
        dec.rs1   = rs1;
        dec.rs2   = rs2;
        dec.rd    = rd;
        dec.alu_op = ALU_ADD;
        known     = 1'b1;
        op1_zero  = 1'b0;
        case (opcode)
            OP_LUI: begin
                dec.ctrl.write_reg = 1'b1;
                dec.ctrl.use_imm   = 1'b1;
                dec.imm            = imm_u;
                op1_zero           = 1'b1;
            end
            OP_AUIPC: begin
                dec.ctrl.write_reg = 1'b1;
                dec.ctrl.use_pc    = 1'b1;
                dec.ctrl.use_imm   = 1'b1;
                dec.imm            = imm_u;
            end
            OP_JAL: begin
                dec.ctrl.jump      = 1'b1;
                dec.ctrl.write_reg = 1'b1;
                dec.ctrl.use_pc    = 1'b1;
                dec.ctrl.use_imm   = 1'b1;
                dec.imm            = imm_j;
            end
            OP_JALR: begin
                dec.ctrl.jump      = 1'b1;
                dec.ctrl.write_reg = 1'b1;
                dec.ctrl.use_imm   = 1'b1;
                dec.imm            = imm_i;
            end
            OP_LOAD: begin
                dec.ctrl.read_mem  = 1'b1;
                dec.ctrl.use_mem   = 1'b1;
                dec.ctrl.write_reg = 1'b1;
                dec.ctrl.use_imm   = 1'b1;
                dec.imm            = imm_i;
            end
            OP_STORE: begin
                dec.ctrl.write_mem = 1'b1;
                dec.ctrl.use_imm   = 1'b1;
                dec.imm            = imm_s;
            end
            OP_BRANCH: begin
                dec.ctrl.branch    = 1'b1;
                dec.alu_op         = ALU_SUB;
                dec.imm            = imm_b;
            end
            OP_ARITH_IMM: begin
                dec.ctrl.write_reg = 1'b1;
                dec.ctrl.use_imm   = 1'b1;
                dec.imm            = imm_i;
                dec.alu_op         = alu_sel(f3, instr[30], 1'b0);
            end
            OP_ARITH: begin
                dec.ctrl.write_reg = 1'b1;
                dec.alu_op         = alu_sel(f3, instr[30], 1'b1);
            end
            default: known = 1'b0;
        endcase

        dec.op1 = op1_zero ? 32'd0 : rf_read(rs1);
        dec.op2 = rf_read(rs2);

        // Register indices beyond the architectural count only matter for
        // the reduced (RV32E) register file.
        dec.ctrl.illegal = !known || (instr[1:0] != 2'b11) ||
                           (rs1_used && {1'b0, rs1} >= NREG) ||
                           (rs2_used && {1'b0, rs2} >= NREG) ||
                           (dec.ctrl.write_reg && {1'b0, rd} >= NREG);
        if (dec.ctrl.illegal) begin
            dec.ctrl.write_reg = 1'b0;
            dec.ctrl.write_mem = 1'b0;
            dec.ctrl.read_mem  = 1'b0;
            dec.ctrl.branch    = 1'b0;
            dec.ctrl.jump      = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // ID/EX register, hazard detection and stall counter
    // ------------------------------------------------------------------
    ex_t              ex_q, ex_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             load_en, hazard;

    assign load_en = !valid_q || bus.ex_ready_i;
    assign hazard  = (HAZARD_EN != 0) && valid_q && ex_q.ctrl.read_mem &&
                     (ex_q.rd != 5'd0) &&
                     ((rs1_used && ex_q.rd == rs1) || (rs2_used && ex_q.rd == rs2));

    assign bus.id_ready_o = bus.flush_i || (load_en && !hazard);

    always_comb begin
        ex_d        = ex_q;
        valid_d     = valid_q;
        stall_cnt_d = stall_cnt_q;
        if (bus.flush_i) begin
            valid_d = 1'b0;
            ex_d.ctrl = '0;
        end else if (load_en) begin
            if (hazard) begin
                valid_d   = 1'b0;
                ex_d.ctrl = '0;
                if (stall_cnt_q != '1) begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                end
            end else begin
                ex_d    = dec;
                valid_d = bus.if_valid_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ex_q        <= '0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.ex_valid_o     = valid_q;
    assign bus.ex_pc_o        = ex_q.pc;
    assign bus.ex_op1_o       = ex_q.op1;
    assign bus.ex_op2_o       = ex_q.op2;
    assign bus.ex_imm_o       = ex_q.imm;
    assign bus.ex_alu_op_o    = ex_q.alu_op;
    assign bus.ex_func3_o     = ex_q.func3;
    assign bus.ex_use_imm_o   = ex_q.ctrl.use_imm;
    assign bus.ex_use_pc_o    = ex_q.ctrl.use_pc;
    assign bus.ex_branch_o    = ex_q.ctrl.branch;
    assign bus.ex_jump_o      = ex_q.ctrl.jump;
    assign bus.ex_read_mem_o  = ex_q.ctrl.read_mem;
    assign bus.ex_write_mem_o = ex_q.ctrl.write_mem;
    assign bus.ex_use_mem_o   = ex_q.ctrl.use_mem;
    assign bus.ex_write_reg_o = ex_q.ctrl.write_reg;
    assign bus.ex_illegal_o   = ex_q.ctrl.illegal;
    assign bus.ex_rs1_o       = ex_q.rs1;
    assign bus.ex_rs2_o       = ex_q.rs2;
    assign bus.ex_rd_o        = ex_q.rd;
    assign bus.stall_cnt_o    = stall_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_instr_decode_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_decode_unit
//  Description : Directed, table-driven bench for instr_decode_unit plus
//                hand-written multi-cycle sequences (bypass, load-use,
//                hold/flush, reset override, RV32E range, counter saturation).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_decode_unit;
    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_fail;

    instr_decode_unit_if                bus ();
    instr_decode_unit_if #(.CNT_W(2))   bus16 ();

    instr_decode_unit #(.NUM_REGS(32), .WB_BYPASS(1), .HAZARD_EN(1), .CNT_W(16)) u_dut (
        .clk(clk), .reset_n(reset_n), .bus(bus));

    instr_decode_unit #(.NUM_REGS(16), .WB_BYPASS(1), .HAZARD_EN(1), .CNT_W(2)) u_dut16 (
        .clk(clk), .reset_n(reset_n), .bus(bus16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [8:0]  flags;   // use_imm,use_pc,branch,jump,rd_mem,wr_mem,use_mem,wr_reg,illegal
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] flags_now();
        return {bus.ex_use_imm_o, bus.ex_use_pc_o, bus.ex_branch_o, bus.ex_jump_o,
                bus.ex_read_mem_o, bus.ex_write_mem_o, bus.ex_use_mem_o,
                bus.ex_write_reg_o, bus.ex_illegal_o};
    endfunction

    task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
        bus.if_valid_i = 1'b1;
        bus.if_instr_i = ins;
        bus.if_pc_i    = pc;
    endtask

    task automatic offer16(input logic [31:0] ins);
        bus16.if_valid_i = 1'b1;
        bus16.if_instr_i = ins;
        bus16.if_pc_i    = 32'h300;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        vecs[0]  = '{32'hFFF00293, 32'hFFFFFFFF, 4'd0, 9'h102, 32'h0,   32'h0,  5'd5};
        vecs[1]  = '{32'h002083B3, 32'h0,        4'd0, 9'h002, 32'h100, 32'h22, 5'd7};
        vecs[2]  = '{32'h40208433, 32'h0,        4'd1, 9'h002, 32'h100, 32'h22, 5'd8};
        vecs[3]  = '{32'h0080A303, 32'h8,        4'd0, 9'h116, 32'h100, 32'h0,  5'd6};
        vecs[4]  = '{32'hFE20AE23, 32'hFFFFFFFC, 4'd0, 9'h108, 32'h100, 32'h22, 5'd28};
        vecs[5]  = '{32'hFE208CE3, 32'hFFFFFFF8, 4'd1, 9'h040, 32'h100, 32'h22, 5'd25};
        vecs[6]  = '{32'h008000EF, 32'h8,        4'd0, 9'h1A2, 32'h0,   32'h0,  5'd1};
        vecs[7]  = '{32'h123454B7, 32'h12345000, 4'd0, 9'h102, 32'h0,   32'h0,  5'd9};
        vecs[8]  = '{32'h00001517, 32'h1000,     4'd0, 9'h182, 32'h0,   32'h0,  5'd10};
        vecs[9]  = '{32'h00408067, 32'h4,        4'd0, 9'h122, 32'h100, 32'h0,  5'd0};
        vecs[10] = '{32'h4020D5B3, 32'h0,        4'd7, 9'h002, 32'h100, 32'h22, 5'd11};
        vecs[11] = '{32'h0030D613, 32'h3,        4'd6, 9'h102, 32'h100, 32'h0,  5'd12};
        vecs[12] = '{32'h7FF0C693, 32'h7FF,      4'd5, 9'h102, 32'h100, 32'h0,  5'd13};
        vecs[13] = '{32'h0000007F, 32'h0,        4'd0, 9'h001, 32'h0,   32'h0,  5'd0};
        vecs[14] = '{32'hFFF00292, 32'h0,        4'd0, 9'h001, 32'h0,   32'h0,  5'd5};
        vecs[15] = '{32'h0020F7B3, 32'h0,        4'd9, 9'h002, 32'h100, 32'h22, 5'd15};
        vecs[16] = '{32'h0020B833, 32'h0,        4'd4, 9'h002, 32'h100, 32'h22, 5'd16};

        // Idle inputs and reset
        reset_n = 1'b0;
        bus.if_valid_i = 1'b0; bus.if_instr_i = '0; bus.if_pc_i = '0;
        bus.wb_rd_addr_i = '0; bus.wb_rd_data_i = '0; bus.wb_rd_write_i = 1'b0;
        bus.ex_ready_i = 1'b1; bus.flush_i = 1'b0;
        bus16.if_valid_i = 1'b0; bus16.if_instr_i = '0; bus16.if_pc_i = '0;
        bus16.wb_rd_addr_i = '0; bus16.wb_rd_data_i = '0; bus16.wb_rd_write_i = 1'b0;
        bus16.ex_ready_i = 1'b1; bus16.flush_i = 1'b0;
        tick(); tick();
        check("reset_valid", 32'(bus.ex_valid_o), 32'd0);
        check("reset_stall", 32'(bus.stall_cnt_o), 32'd0);
        check("reset_pc",    bus.ex_pc_o, 32'd0);
        check("reset_flags", 32'(flags_now()), 32'd0);
        check("reset_ready", 32'(bus.id_ready_o), 32'd1);
        reset_n = 1'b1;

        // Preload x1, x2 through the WB port
        bus.wb_rd_write_i = 1'b1;
        bus.wb_rd_addr_i = 5'd1; bus.wb_rd_data_i = 32'h100; tick();
        bus.wb_rd_addr_i = 5'd2; bus.wb_rd_data_i = 32'h22;  tick();
        bus.wb_rd_write_i = 1'b0;

        // Table-driven single-instruction decode
        for (int i = 0; i < 17; i++) begin
            offer(vecs[i].instr, 32'h1000 + 32'(i) * 4);
            #1;
            check($sformatf("v%0d_ready", i), 32'(bus.id_ready_o), 32'd1);
            tick();
            check($sformatf("v%0d_valid", i), 32'(bus.ex_valid_o), 32'd1);
            check($sformatf("v%0d_pc", i),    bus.ex_pc_o, 32'h1000 + 32'(i) * 4);
            check($sformatf("v%0d_imm", i),   bus.ex_imm_o, vecs[i].imm);
            check($sformatf("v%0d_alu", i),   32'(bus.ex_alu_op_o), 32'(vecs[i].alu));
            check($sformatf("v%0d_flags", i), 32'(flags_now()), 32'(vecs[i].flags));
            check($sformatf("v%0d_op1", i),   bus.ex_op1_o, vecs[i].op1);
            check($sformatf("v%0d_op2", i),   bus.ex_op2_o, vecs[i].op2);
            check($sformatf("v%0d_rd", i),    32'(bus.ex_rd_o), 32'(vecs[i].rd));
        end
        check("table_stall", 32'(bus.stall_cnt_o), 32'd0);

        // WB write-through: add x4,x3,x0 while x3 is being written
        bus.wb_rd_write_i = 1'b1; bus.wb_rd_addr_i = 5'd3; bus.wb_rd_data_i = 32'h12345678;
        offer(32'h00018233, 32'h1100);
        tick();
        check("bypass_op1", bus.ex_op1_o, 32'h12345678);
        // x0 write ignored, x3 now stored: add x4,x0,x3
        bus.wb_rd_addr_i = 5'd0; bus.wb_rd_data_i = 32'hDEADBEEF;
        offer(32'h00300233, 32'h1104);
        tick();
        bus.wb_rd_write_i = 1'b0;
        check("x0_bypass_op1", bus.ex_op1_o, 32'h0);
        check("rf_x3_op2",     bus.ex_op2_o, 32'h12345678);
        offer(32'h00000233, 32'h1108);
        tick();
        check("x0_stored_op1", bus.ex_op1_o, 32'h0);

        // Load-use: lw x6,0(x1) ; add x7,x6,x2
        offer(32'h0000A303, 32'h1200);
        tick();
        offer(32'h002303B3, 32'h1204);
        #1;
        check("lu_ready_low", 32'(bus.id_ready_o), 32'd0);
        tick();
        check("lu_bubble_valid", 32'(bus.ex_valid_o), 32'd0);
        check("lu_bubble_flags", 32'(flags_now()), 32'd0);
        check("lu_stall_cnt",    32'(bus.stall_cnt_o), 32'd1);
        check("lu_ready_back",   32'(bus.id_ready_o), 32'd1);
        tick();
        check("lu_add_valid", 32'(bus.ex_valid_o), 32'd1);
        check("lu_add_pc",    bus.ex_pc_o, 32'h1204);
        check("lu_add_rd",    32'(bus.ex_rd_o), 32'd7);

        // Hold for 3 cycles with EX not ready, then flush
        offer(32'h40208433, 32'h2000);
        tick();
        bus.ex_ready_i = 1'b0;
        offer(32'hFFF00293, 32'h2004);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("hold%0d_ready", k), 32'(bus.id_ready_o), 32'd0);
            tick();
            check($sformatf("hold%0d_valid", k), 32'(bus.ex_valid_o), 32'd1);
            check($sformatf("hold%0d_pc", k),    bus.ex_pc_o, 32'h2000);
            check($sformatf("hold%0d_alu", k),   32'(bus.ex_alu_op_o), 32'd1);
        end
        bus.flush_i = 1'b1;
        #1;
        check("flush_ready", 32'(bus.id_ready_o), 32'd1);
        tick();
        bus.flush_i = 1'b0;
        check("flush_valid", 32'(bus.ex_valid_o), 32'd0);
        check("flush_flags", 32'(flags_now()), 32'd0);

        // Reset during hold with flush also asserted
        bus.ex_ready_i = 1'b1;
        offer(32'h40208433, 32'h2100);
        tick();
        bus.ex_ready_i = 1'b0; bus.flush_i = 1'b1; reset_n = 1'b0;
        tick();
        check("rst_hold_valid", 32'(bus.ex_valid_o), 32'd0);
        check("rst_hold_pc",    bus.ex_pc_o, 32'd0);
        check("rst_hold_stall", 32'(bus.stall_cnt_o), 32'd0);
        reset_n = 1'b1; bus.flush_i = 1'b0; bus.ex_ready_i = 1'b1;
        offer(32'h002083B3, 32'h2200);
        tick();
        check("rst_rf_valid", 32'(bus.ex_valid_o), 32'd1);
        check("rst_rf_op1",   bus.ex_op1_o, 32'h0);
        check("rst_rf_op2",   bus.ex_op2_o, 32'h0);

        // NUM_REGS=16: add x20,x1,x2 illegal, add x5,x1,x2 legal
        offer16(32'h00208A33);
        tick();
        check("e_x20_valid",   32'(bus16.ex_valid_o), 32'd1);
        check("e_x20_illegal", 32'(bus16.ex_illegal_o), 32'd1);
        check("e_x20_wreg",    32'(bus16.ex_write_reg_o), 32'd0);
        offer16(32'h002082B3);
        tick();
        check("e_x5_illegal", 32'(bus16.ex_illegal_o), 32'd0);
        check("e_x5_wreg",    32'(bus16.ex_write_reg_o), 32'd1);

        // 2-bit stall counter saturates at 3
        for (int k = 1; k <= 4; k++) begin
            offer16(32'h0000A303); tick();
            offer16(32'h002303B3); tick(); tick();
            check($sformatf("sat%0d_stall", k), 32'(bus16.stall_cnt_o), (k > 3) ? 32'd3 : 32'(k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
